// File: rtl/npc.sv
// Next-PC selection for the multicycle core: picks sequential, branch, jump or
// jump-register target and registers it onto pcout every cycle.
module npc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned WIDTH    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pcin,
    input  logic [WIDTH-1:0] pc_ori,
    input  logic [1:0]       npc_sel,
    input  logic             zero,
    input  logic [WIDTH-1:0] imm32,
    output logic [WIDTH-1:0] pcout
);

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;
    localparam logic [1:0] SEL_JR     = 2'b11;

    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] nxt;

    // Shift drops imm32[31:30]; carry out of the add is discarded so it wraps.
    assign branch_target = pcin + {imm32[WIDTH-3:0], 2'b00};

    // Region-relative jump keeps the top nibble of the sequential address.
    assign jump_target = {pcin[WIDTH-1:WIDTH-4], imm32[25:0], 2'b00};

    always_comb begin
        nxt = pcin;
        unique case (npc_sel)
            SEL_SEQ:    nxt = pcin;
            SEL_BRANCH: nxt = zero ? branch_target : pcin;
            SEL_JUMP:   nxt = jump_target;
            SEL_JR:     nxt = imm32;
            default:    nxt = pcin;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcout <= RESET_PC;
        end else begin
            pcout <= nxt;
        end
    end

    // pc_ori is carried for debug visibility only and never steers nxt.
    logic unused_pc_ori;
    assign unused_pc_ori = ^pc_ori;

endmodule

// File: tb/tb_npc.sv
// Self-checking bench for npc: directed cases plus randomized traffic checked
// against an arithmetic reference model.
module tb_npc;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk;
    logic        rst;
    logic [31:0] pcin;
    logic [31:0] pc_ori;
    logic [1:0]  npc_sel;
    logic        zero;
    logic [31:0] imm32;
    logic [31:0] pcout;

    int n_checks;
    int n_pass;
    int n_fail;

    npc #(
        .RESET_PC(RESET_PC),
        .WIDTH   (32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pcin   (pcin),
        .pc_ori (pc_ori),
        .npc_sel(npc_sel),
        .zero   (zero),
        .imm32  (imm32),
        .pcout  (pcout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: next PC computed with plain 64-bit arithmetic and masks.
    function automatic logic [31:0] model(input logic [1:0] sel, input logic z,
                                          input logic [31:0] pi, input logic [31:0] im);
        longint unsigned sum;
        longint unsigned region;
        longint unsigned index;
        case (sel)
            2'd1: begin
                if (z) begin
                    sum = longint'(pi) + (longint'(im) * 4);
                    return 32'(sum % 64'h1_0000_0000);
                end
                return pi;
            end
            2'd2: begin
                region = longint'(pi) & 64'hF000_0000;
                index  = (longint'(im) % 64'h400_0000) * 4;
                return 32'(region + index);
            end
            2'd3:    return im;
            default: return pi;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: pcout=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] sel, input logic z, input logic [31:0] pi,
                         input logic [31:0] po, input logic [31:0] im);
        npc_sel = sel;
        zero    = z;
        pcin    = pi;
        pc_ori  = po;
        imm32   = im;
    endtask

    task automatic step(input string tag, input logic [1:0] sel, input logic z,
                        input logic [31:0] pi, input logic [31:0] po, input logic [31:0] im);
        drive(sel, z, pi, po, im);
        @(posedge clk);
        #1;
        check(tag, pcout, model(sel, z, pi, im));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(2'b11, 1'b1, 32'hDEAD_BEEC, 32'hDEAD_BEE8, 32'h1234_5678);

        // Asynchronous assertion, before any clock edge.
        #2 rst = 1'b0;
        #1 check("reset_async", pcout, RESET_PC);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", pcout, RESET_PC);

        // Release; the next edge loads the sequential address.
        drive(2'b00, 1'b0, 32'h1111_1108, 32'h1111_1104, 32'h0000_00AC);
        rst = 1'b1;
        @(posedge clk);
        #1 check("seq", pcout, 32'h1111_1108);

        step("branch_nt", 2'b01, 1'b0, 32'h1111_1108, 32'h1111_1104, 32'h0000_00AC);
        check("branch_nt_const", pcout, 32'h1111_1108);
        step("branch_t", 2'b01, 1'b1, 32'h1111_1108, 32'h1111_1104, 32'h0000_00AC);
        check("branch_t_const", pcout, 32'h1111_13B8);
        step("jump", 2'b10, 1'b1, 32'h1111_1108, 32'h1111_1104, 32'h0000_00AC);
        check("jump_const", pcout, 32'h1000_02B0);
        step("jr", 2'b11, 1'b0, 32'h1111_1108, 32'h1111_1104, 32'h0000_00AC);
        check("jr_const", pcout, 32'h0000_00AC);
        step("branch_back", 2'b01, 1'b1, 32'h0000_0010, 32'h0000_000C, 32'hFFFF_FFFE);
        check("branch_back_const", pcout, 32'h0000_0008);
        step("branch_wrap", 2'b01, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h0000_0001);
        check("branch_wrap_const", pcout, 32'h0000_0000);
        step("jump_hi_ignored", 2'b10, 1'b0, 32'hA000_0000, 32'h0, 32'hFC00_0001);
        check("jump_hi_const", pcout, 32'hA000_0004);
        step("jr_unaligned", 2'b11, 1'b1, 32'h0, 32'h0, 32'h8000_0003);
        step("seq_zero_ignored", 2'b00, 1'b1, 32'h0040_0000, 32'h0, 32'h7FFF_FFFF);

        // Inputs toggled between edges must not reach pcout early.
        #2 drive(2'b11, 1'b1, 32'h0, 32'h0, 32'h5555_5554);
        #1 check("mid_cycle_hold", pcout, 32'h0040_0000);
        @(posedge clk);
        #1 check("mid_cycle_load", pcout, 32'h5555_5554);

        for (int i = 0; i < 300; i++) begin
            step("random", 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
                 $urandom);
        end

        // Reset asserted mid-run.
        #2 rst = 1'b0;
        #1 check("reset_midrun", pcout, RESET_PC);
        @(posedge clk);
        #1 check("reset_midrun_hold", pcout, RESET_PC);
        drive(2'b10, 1'b0, 32'h3000_0000, 32'h0, 32'h0000_0100);
        rst = 1'b1;
        @(posedge clk);
        #1 check("reset_release", pcout, 32'h3000_0400);

        for (int i = 0; i < 100; i++) begin
            step("random2", 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
                 $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/npc.md
Name: npc

Overview:
- Next-PC selection unit for the multicycle MIPS-style processor.
- Each cycle it picks one of four next-PC sources: sequential, conditional branch, J-type jump, or register jump.
- The selection comes from the control unit's npc_sel and the ALU zero flag.
- The chosen address is registered onto pcout, which feeds the PC / instruction-fetch path.

Parameters:
- RESET_PC, 32'h0000_3000, value loaded into pcout while reset is asserted.
- WIDTH, 32, address width. Only 32 is supported.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  asynchronous reset, active-low; rst=0 forces pcout to RESET_PC.
- pcin  input  32  sequential address (PC+4 produced by the PC adder).
- pc_ori  input  32  address of the current instruction (un-incremented PC); provided for debug and upper-bit use.
- npc_sel  input  2  source select: 00 seq, 01 branch, 10 jump, 11 jump-register.
- zero  input  1  ALU zero flag; qualifies the branch.
- imm32  input  32  sign-extended branch offset / jump index / register target, depending on npc_sel.
- pcout  output  32  registered next-PC.

Behaviour:
- Reset:
  - Asynchronous, active-low: rst=0 immediately sets pcout=RESET_PC, independent of clk.
  - pcout holds RESET_PC while rst=0.
  - Deassertion takes effect at the next rising clk.
- Latency: one cycle. The combinational target nxt is computed from the current inputs and captured into pcout on each rising clk while rst=1. There is no enable; pcout updates every cycle.
- Target selection:
  - npc_sel=00: nxt = pcin.
  - npc_sel=01: if zero=1, nxt = pcin + (imm32 << 2), modulo 2^32; if zero=0, nxt = pcin.
  - npc_sel=10: nxt = {pcin[31:28], imm32[25:0], 2'b00}. imm32[31:26] is ignored.
  - npc_sel=11: nxt = imm32 unchanged. No alignment forcing; imm32 carries the register value.
- zero is ignored for every npc_sel other than 01.
- Arithmetic:
  - The branch add is 32-bit; carry out is discarded, so it wraps.
  - imm32 is already sign-extended; the shift-left-2 discards imm32[31:30].
  - Negative offsets therefore branch backwards.
- pc_ori does not affect nxt. It is carried for observability only and must not create a latch or be optimized into the result.
- Input changes between clock edges do not affect pcout until the next rising edge.
- No X propagation: all four npc_sel codes are defined.

Test Plan:
- Reset: drive rst=0 with arbitrary inputs -> pcout=32'h0000_3000 immediately, without a clock edge. Release rst=1 -> the next edge loads nxt.
- Sequential: pcin=32'h1111_1108, pc_ori=32'h1111_1104, imm32=32'h0000_00AC, npc_sel=00, zero=0, clk edge -> pcout=32'h1111_1108.
- Branch not taken / taken, same inputs:
  - npc_sel=01, zero=0 -> pcout=32'h1111_1108.
  - Then zero=1 -> pcout=32'h1111_13B8 (0x11111108 + 0x2B0).
- Jump: npc_sel=10, zero=1, same inputs -> pcout=32'h1000_02B0.
- Jump-register: npc_sel=11 -> pcout=32'h0000_00AC.
- Boundaries:
  - Backward branch: pcin=32'h0000_0010, imm32=32'hFFFF_FFFE, npc_sel=01, zero=1 -> pcout=32'h0000_0008.
  - Wrap: pcin=32'hFFFF_FFFC, imm32=1 -> pcout=32'h0000_0000.
  - Reset asserted mid-run -> pcout=RESET_PC asynchronously.
